data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Parametrised data memory for the riscv core, replacing the fixed 256-byte, always-32-bit data RAM.
//   - Handles RV32I byte/half/word loads and stores, selected by funct3: sign/zero extension, byte-lane writes.
//   - Configurable wait-state latency behind a valid/ready request handshake and a one-cycle response pulse.
//   - Sits between the ALU address/rs2 path and the write-back mux.
// PARAMETERS
//   ADDR_WIDTH   10  byte-address width; storage = 2**(ADDR_WIDTH-2) words x 32 bits, 4 byte lanes
//   WAIT_STATES  1   extra cycles between request acceptance and response, 0..15
// PORTS
//   clock       in   1           rising-edge clock
//   clear       in   1           asynchronous reset, active low
//   req_valid   in   1           request present
//   req_ready   out  1           block can accept a request (high only in IDLE)
//   req_we      in   1           1 = store, 0 = load
//   req_funct3  in   3           RV32I funct3 of the load/store
//   req_addr    in   ADDR_WIDTH  byte address
//   req_wdata   in   32          store data, taken from the low bits
//   rsp_valid   out  1           one-cycle pulse: request completed
//   rsp_rdata   out  32          load result, extended to 32 bits; 0 for stores and errors
//   rsp_err     out  1           misaligned or illegal access; qualified by rsp_valid
//   busy        out  1           ~req_ready
// BEHAVIOUR
//   - Reset (clear=0, asynchronous): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
//     Memory contents are not cleared.
//   - FSM: IDLE -> WAIT -> RESP -> IDLE.
//     - IDLE: on req_valid&&req_ready, latch we/funct3/addr/wdata. Go to WAIT, or to RESP if WAIT_STATES=0.
//     - WAIT: counts WAIT_STATES cycles, then goes to RESP.
//     - RESP: lasts one cycle, then returns to IDLE unconditionally. There is no response back-pressure.
//   - Latency: rsp_valid is high exactly WAIT_STATES+1 cycles after the acceptance edge.
//     The next request can be accepted in the cycle after RESP.
//     Requests presented while busy are ignored (not queued); the master holds them.
//   - Memory access happens on the edge entering RESP.
//     - Stores write only their enabled byte lanes.
//     - Loads sample the word on that edge; rsp_rdata and rsp_err are registered and valid during RESP.
//     - rsp_rdata and rsp_err hold their value until the next RESP.
//   - Word index = addr[ADDR_WIDTH-1:2]. Byte lane = addr[1:0]. Half select = addr[1].
//   - Loads:
//     - 000 LB: sign-extend the byte. 100 LBU: zero-extend the byte.
//     - 001 LH: sign-extend the half. 101 LHU: zero-extend the half.
//     - 010 LW: the full word.
//   - Stores: 000 SB writes wdata[7:0] to lane addr[1:0]; 001 SH writes wdata[15:0] to half addr[1]; 010 SW writes the word.
//   - Illegal funct3 (load 011/110/111, store 011..111): no write, rsp_rdata=0, rsp_err=1.
//   - Reset while in WAIT: the request is dropped and a pending store is not performed.
//     Reset while in RESP: the store has already been performed.
//   - Address wrap: the top word is independent; no carry into other words.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined:
//     - Half access with addr[0]=1, or word access with addr[1:0]!=0: no write, rsp_rdata=0, rsp_err=1.
//   DMEM_MISALIGN_TRAP_EN undefined:
//     - Offending low address bits are ignored: half uses addr[1]; word uses addr[1:0]=00.
//     - The access completes normally; rsp_err is set only for illegal funct3.
// TESTING
//   1 SW addr 0x000 data 0xDEADBEEF, then LW 0x000 -> rsp_rdata=0xDEADBEEF, rsp_valid at acceptance+2 (WAIT_STATES=1).
//   2 LB 0x003 -> 0xFFFFFFDE; LBU 0x003 -> 0x000000DE; LH 0x002 -> 0xFFFFDEAD; LHU 0x002 -> 0x0000DEAD.
//   3 SB 0x001 data 0x55, SH 0x002 data 0x1234, then LW 0x000 -> 0x123455EF; other words unchanged.
//   4 LW 0x001 and SH 0x003: macro on -> rsp_err=1, rdata=0, memory unchanged; macro off -> aligned access, rsp_err=0.
//   5 req_valid held high across 3 requests -> req_ready low from acceptance through RESP, no request lost or duplicated.
//     WAIT_STATES=0 -> latency 1.
//   6 SW 0x010 data 0xCAFEF00D, assert clear during WAIT -> req_ready=1, rsp_valid=0; LW 0x010 returns the old word.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I data memory with byte/half/word access and configurable wait states
// Optional macro DMEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses as errors instead of aligning them.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    lat_we;
  logic [2:0]              lat_funct3;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    enter_resp;
  logic                    acc_we;
  logic [2:0]              acc_funct3;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_wdata;
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic [1:0]              lane;
  logic [31:0]             word;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    illegal;
  logic                    misalign;
  logic                    err;
  logic [3:0]              be;
  logic [31:0]             wd;
  logic [31:0]             ld;
  logic [31:0]             ld_out;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_STATES == 0)) || (state == S_WAIT && wait_cnt == WS_LAST);
  assign busy       = ~req_ready;

  // With zero wait states the access happens on the acceptance edge, so use the live request.
  assign acc_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign acc_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;

  assign word_idx = acc_addr[ADDR_WIDTH-1:2];
  assign lane     = acc_addr[1:0];
  assign word     = mem[word_idx];
  assign byte_v   = word[{lane, 3'b000} +: 8];
  assign half_v   = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    illegal  = acc_we ? (acc_funct3 > 3'd2)
                      : (acc_funct3[1:0] == 2'b11 || acc_funct3 == 3'b110);
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (acc_funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = (lane != 2'b00);
      default: misalign = 1'b0;
    endcase
`endif
    err = illegal || misalign;

    case (acc_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{acc_wdata[7:0]}};
        ld = {{24{byte_v[7] & ~acc_funct3[2]}}, byte_v};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{acc_wdata[15:0]}};
        ld = {{16{half_v[15] & ~acc_funct3[2]}}, half_v};
      end
      default: begin
        be = 4'b1111;
        wd = acc_wdata;
        ld = word;
      end
    endcase

    if (err || !acc_we) be = 4'b0000;
    ld_out = (err || acc_we) ? 32'd0 : ld;
  end

  // Storage is never reset; clear gating keeps a store from landing on a reset edge.
  always_ff @(posedge clock) begin
    if (enter_resp && clear) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
    end else begin
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_rdata <= ld_out;
        rsp_err   <= err;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            wait_cnt   <= 4'd0;
            state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WS_LAST) begin
            wait_cnt <= 4'd0;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  localparam int AW = 10;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic          req_valid, req_ready, req_we, rsp_valid, rsp_err, busy;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata, rsp_rdata;

  logic          z_valid, z_ready, z_we, z_rsp_valid, z_err, z_busy;
  logic [2:0]    z_f3;
  logic [AW-1:0] z_addr;
  logic [31:0]   z_wdata, z_rdata;

  int checks = 0;
  int fails  = 0;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clock(clock), .clear(clear), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_funct3(z_f3), .req_addr(z_addr), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err), .busy(z_busy)
  );

  task automatic access(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wdv, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wdv;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (rsp_valid) begin
      rd = rsp_rdata; er = rsp_err;
    end else begin
      rd = 'x; er = 1'bx;
    end
  endtask

  task automatic test_reset;
    clear = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    z_valid = 1'b0; z_we = 1'b0; z_f3 = 3'd0; z_addr = '0; z_wdata = '0;
    repeat (2) @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset_rsp: got rdata %h err %b expected 00000000 0", rsp_rdata, rsp_err);
    end
    clear = 1'b1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 3'b010, 10'h000, 32'hDEADBEEF, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin
      fails++; $display("FAIL sw_rsp: got rdata %h err %b expected 00000000 0", rd, er);
    end
    access(1'b0, 3'b010, 10'h000, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    checks++; if (lat !== 2) begin fails++; $display("FAIL lw_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_subword_loads;
    logic [2:0]    f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [AW-1:0] ads [6] = '{10'h003, 10'h003, 10'h002, 10'h002, 10'h000, 10'h000};
    logic [31:0]   exp [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                               32'hFFFFFFEF, 32'hFFFFBEEF};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 6; i++) begin
      access(1'b0, f3s[i], ads[i], 32'd0, rd, er, lat);
      checks++; if (rd !== exp[i] || er !== 1'b0) begin
        fails++; $display("FAIL load_%0d: got %h err %b expected %h err 0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_store_lanes;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 3'b010, 10'h004, 32'h11223344, rd, er, lat);
    access(1'b1, 3'b000, 10'h001, 32'hFFFFFF55, rd, er, lat);
    access(1'b1, 3'b001, 10'h002, 32'hFFFF1234, rd, er, lat);
    access(1'b0, 3'b010, 10'h000, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h123455EF) begin fails++; $display("FAIL lanes_word0: got %h expected 123455ef", rd); end
    access(1'b0, 3'b010, 10'h004, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h11223344) begin fails++; $display("FAIL lanes_word1: got %h expected 11223344", rd); end
    access(1'b1, 3'b010, 10'h3FC, 32'h89ABCDEF, rd, er, lat);
    access(1'b0, 3'b000, 10'h3FF, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF89) begin fails++; $display("FAIL top_byte: got %h expected ffffff89", rd); end
    access(1'b0, 3'b010, 10'h000, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h123455EF) begin fails++; $display("FAIL wrap_word0: got %h expected 123455ef", rd); end
  endtask

  task automatic test_misalign_illegal;
    logic [31:0] rd; logic er; int lat;
    access(1'b0, 3'b010, 10'h001, 32'd0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin
      fails++; $display("FAIL lw_misalign: got %h err %b expected 00000000 1", rd, er);
    end
`else
    checks++; if (rd !== 32'h123455EF || er !== 1'b0) begin
      fails++; $display("FAIL lw_misalign: got %h err %b expected 123455ef 0", rd, er);
    end
`endif
    access(1'b1, 3'b001, 10'h003, 32'h0000ABCD, rd, er, lat);
    access(1'b0, 3'b010, 10'h000, 32'd0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 32'h123455EF) begin fails++; $display("FAIL sh_misalign: got %h expected 123455ef", rd); end
`else
    checks++; if (rd !== 32'hABCD55EF) begin fails++; $display("FAIL sh_misalign: got %h expected abcd55ef", rd); end
`endif
    access(1'b0, 3'b110, 10'h000, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin
      fails++; $display("FAIL load_illegal: got %h err %b expected 00000000 1", rd, er);
    end
    access(1'b1, 3'b011, 10'h004, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL store_illegal_err: got %b expected 1", er); end
    access(1'b0, 3'b010, 10'h004, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h11223344) begin fails++; $display("FAIL store_illegal_mem: got %h expected 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3] = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003};
    logic [31:0] rd; logic er; int lat;
    int acc = 0, nrsp = 0, bad = 0;
    bit infl = 0;
    for (int i = 0; i < 3; i++) access(1'b1, 3'b010, 10'(32'h20 + 4 * i), exp[i], rd, er, lat);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h020;
    for (int c = 0; c < 30; c++) begin
      if (infl && req_ready) bad++;
      if (rsp_valid) begin
        checks++; if (nrsp > 2 || rsp_rdata !== exp[nrsp > 2 ? 2 : nrsp]) begin
          fails++; $display("FAIL b2b_data_%0d: got %h expected %h", nrsp, rsp_rdata, exp[nrsp > 2 ? 2 : nrsp]);
        end
        nrsp++;
        infl = 0;
      end
      if (req_ready && req_valid) begin
        @(posedge clock);
        #1;
        acc++; infl = 1;
        if (acc < 3) req_addr = 10'(32'h20 + 4 * acc);
        else req_valid = 1'b0;
      end
      @(negedge clock);
    end
    checks++; if (acc !== 3 || nrsp !== 3) begin
      fails++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 3 3", acc, nrsp);
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL b2b_ready_low: got %0d ready-while-busy cycles expected 0", bad); end

    z_valid = 1'b1; z_we = 1'b1; z_f3 = 3'b010; z_addr = 10'h000; z_wdata = 32'h0BADCAFE;
    @(posedge clock);
    #1 z_valid = 1'b0;
    @(negedge clock);
    checks++; if (z_rsp_valid !== 1'b1) begin fails++; $display("FAIL ws0_store_latency: got %b expected 1", z_rsp_valid); end
    @(negedge clock);
    z_valid = 1'b1; z_we = 1'b0;
    @(posedge clock);
    #1 z_valid = 1'b0;
    @(negedge clock);
    checks++; if (z_rsp_valid !== 1'b1 || z_rdata !== 32'h0BADCAFE) begin
      fails++; $display("FAIL ws0_load: got valid %b data %h expected 1 0badcafe", z_rsp_valid, z_rdata);
    end
  endtask

  task automatic test_reset_mid_request;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 3'b010, 10'h010, 32'h5A5A5A5A, rd, er, lat);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h010; req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1 req_valid = 1'b0;
    #2 clear = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL wait_reset: got ready %b valid %b expected 1 0", req_ready, rsp_valid);
    end
    clear = 1'b1;
    access(1'b0, 3'b010, 10'h010, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h5A5A5A5A) begin fails++; $display("FAIL wait_reset_mem: got %h expected 5a5a5a5a", rd); end

    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h014; req_wdata = 32'h00000077;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    access(1'b0, 3'b010, 10'h014, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'h00000077) begin fails++; $display("FAIL resp_reset_mem: got %h expected 00000077", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_subword_loads;
    test_store_lanes;
    test_misalign_illegal;
    test_back_to_back;
    test_reset_mid_request;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
